// File: rtl/fft_mag_peak.sv
// Squared-magnitude stream and per-frame peak finder behind the FFT core.
// Optional build macro SPEC_DC_SKIP_EN removes bin 0 from the peak search.
module fft_mag_peak #(
  parameter int FFT_LEN = 2048,
  parameter int ADDR_W  = 11,
  parameter int DW      = 16
) (
  input  logic              i_aclk,
  input  logic              i_aresetn,
  input  logic [2*DW-1:0]   i_fft_tdata,
  input  logic              i_fft_tvalid,
  input  logic              i_fft_tlast,
  output logic [2*DW-1:0]   o_mag_tdata,
  output logic [ADDR_W-1:0] o_mag_tuser,
  output logic              o_mag_tvalid,
  output logic              o_mag_tlast,
  output logic [ADDR_W-1:0] o_peak_bin,
  output logic [2*DW-1:0]   o_peak_mag,
  output logic              o_peak_valid,
  output logic              o_frame_err
);

  localparam int PW = 2 * DW;
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_LEN - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Squares are non-negative, so the sum is formed unsigned and any carry
  // past PW bits is dropped.
  function automatic logic [PW-1:0] sum_sq(input logic signed [PW-1:0] a,
                                           input logic signed [PW-1:0] b);
    return $unsigned(a) + $unsigned(b);
  endfunction

  logic signed [DW-1:0] re_in, im_in;
  logic signed [PW-1:0] re_x, im_x;
  logic [ADDR_W-1:0]    cnt;
  logic                 at_end, last_in;

  assign re_in   = i_fft_tdata[DW-1:0];
  assign im_in   = i_fft_tdata[2*DW-1:DW];
  assign re_x    = PW'(re_in);
  assign im_x    = PW'(im_in);
  assign at_end  = (cnt == LAST_BIN);
  assign last_in = i_fft_tlast | at_end;

  // ---- stage 1: squares, bin tag, frame end ----
  logic signed [PW-1:0] re_sq_p1, im_sq_p1;
  logic [ADDR_W-1:0]    bin_p1;
  logic                 last_p1, vld_p1;

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      cnt         <= '0;
      vld_p1      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      vld_p1 <= i_fft_tvalid;
      if (i_fft_tvalid) begin
        cnt <= last_in ? '0 : cnt + ADDR_W'(1);
        if (i_fft_tlast != at_end) o_frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_fft_tvalid) begin
      re_sq_p1 <= re_x * re_x;
      im_sq_p1 <= im_x * im_x;
      bin_p1   <= cnt;
      last_p1  <= last_in;
    end
  end

  // ---- stage 2: magnitude output and shadow peak tracker ----
  logic [PW-1:0]     mag_sum;
  logic [ADDR_W-1:0] trk_bin;
  logic [PW-1:0]     trk_mag;
  logic              trk_load, trk_skip;

  assign mag_sum = sum_sq(re_sq_p1, im_sq_p1);

`ifdef SPEC_DC_SKIP_EN
  assign trk_skip = (bin_p1 == '0);
  assign trk_load = (bin_p1 == ADDR_W'(1));
`else
  assign trk_skip = 1'b0;
  assign trk_load = (bin_p1 == '0);
`endif

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      o_mag_tdata  <= '0;
      o_mag_tuser  <= '0;
      o_mag_tvalid <= 1'b0;
      o_mag_tlast  <= 1'b0;
    end else begin
      o_mag_tvalid <= vld_p1;
      o_mag_tlast  <= vld_p1 & last_p1;
      if (vld_p1) begin
        o_mag_tdata <= mag_sum;
        o_mag_tuser <= bin_p1;
      end
    end
  end

  // Tracker keeps running into the next frame; the report is latched from it
  // in S_DONE before the new frame's first bin overwrites it.
  always_ff @(posedge i_aclk) begin
    if (vld_p1) begin
      if (trk_skip) begin
        trk_bin <= '0;
        trk_mag <= '0;
      end else if (trk_load || (mag_sum > trk_mag)) begin
        trk_bin <= bin_p1;
        trk_mag <= mag_sum;
      end
    end
  end

  // ---- stage 3: frame FSM and peak report ----
  logic [1:0] state;
  logic       in_flight;

  assign in_flight = i_fft_tvalid | vld_p1 | (cnt != '0);

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      state        <= S_IDLE;
      o_peak_valid <= 1'b0;
      o_peak_bin   <= '0;
      o_peak_mag   <= '0;
    end else begin
      o_peak_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        o_peak_bin <= trk_bin;
        o_peak_mag <= trk_mag;
      end
      if (vld_p1 && last_p1) begin
        state <= S_DONE;
      end else begin
        case (state)
          S_IDLE:  if (i_fft_tvalid) state <= S_RUN;
          S_DONE:  state <= in_flight ? S_RUN : S_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak; each task drives one scenario and checks inline.
module tb_fft_mag_peak;
  localparam int N = 2048;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] i_fft_tdata;
  logic        i_fft_tvalid, i_fft_tlast;
  logic [31:0] o_mag_tdata, o_peak_mag;
  logic [10:0] o_mag_tuser, o_peak_bin;
  logic        o_mag_tvalid, o_mag_tlast, o_peak_valid, o_frame_err;

  always #5 clk = ~clk;

  fft_mag_peak #(.FFT_LEN(N), .ADDR_W(11), .DW(16)) dut (
    .i_aclk(clk), .i_aresetn(rstn),
    .i_fft_tdata(i_fft_tdata), .i_fft_tvalid(i_fft_tvalid), .i_fft_tlast(i_fft_tlast),
    .o_mag_tdata(o_mag_tdata), .o_mag_tuser(o_mag_tuser), .o_mag_tvalid(o_mag_tvalid),
    .o_mag_tlast(o_mag_tlast), .o_peak_bin(o_peak_bin), .o_peak_mag(o_peak_mag),
    .o_peak_valid(o_peak_valid), .o_frame_err(o_frame_err));

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int tlast_cyc = 0;
  int cap_cnt = 0;
  int ntl = 0;
  int last_cyc = 0;
  int npulse = 0;
  logic [10:0] tl_bin = '0;
  logic [10:0] last_tuser = '0;
  logic [31:0] last_mag = '0;
  logic [31:0] cap_mag [0:N-1];
  logic [10:0] pb [0:7];
  logic [31:0] pm [0:7];
  int          pc [0:7];
  logic signed [15:0] fr_re [0:N-1];
  logic signed [15:0] fr_im [0:N-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_mag_tvalid) begin
      cap_mag[o_mag_tuser] <= o_mag_tdata;
      cap_cnt    <= cap_cnt + 1;
      last_tuser <= o_mag_tuser;
      last_mag   <= o_mag_tdata;
      if (o_mag_tlast) begin
        ntl      <= ntl + 1;
        tl_bin   <= o_mag_tuser;
        last_cyc <= cyc;
      end
    end
    if (o_peak_valid) begin
      if (npulse < 8) begin
        pb[npulse] <= o_peak_bin;
        pm[npulse] <= o_peak_mag;
        pc[npulse] <= cyc;
      end
      npulse <= npulse + 1;
    end
  end

  task automatic drive(input logic signed [15:0] re, input logic signed [15:0] im,
                       input logic last);
    i_fft_tdata  = {im, re};
    i_fft_tvalid = 1'b1;
    i_fft_tlast  = last;
    @(posedge clk);
    if (last) tlast_cyc = cyc;
    #1;
    i_fft_tvalid = 1'b0;
    i_fft_tlast  = 1'b0;
    i_fft_tdata  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    i_fft_tvalid = 1'b0;
    i_fft_tlast  = 1'b0;
    i_fft_tdata  = '0;
    idle(3);
    rstn = 1'b1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic send_frame(input int n, input logic with_last, input logic gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 97 == 50)) idle(2);
      drive(fr_re[i], fr_im[i], with_last && (i == n - 1));
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    i_fft_tvalid = 1'b1;
    i_fft_tdata  = 32'h0003_0004;
    i_fft_tlast  = 1'b0;
    idle(3);
    nchk++; if (o_mag_tvalid !== 1'b0) begin nerr++; $display("FAIL rst_mag_tvalid got %b want 0", o_mag_tvalid); end
    nchk++; if (o_mag_tdata !== 32'd0) begin nerr++; $display("FAIL rst_mag_tdata got %0d want 0", o_mag_tdata); end
    nchk++; if (o_mag_tuser !== 11'd0) begin nerr++; $display("FAIL rst_mag_tuser got %0d want 0", o_mag_tuser); end
    nchk++; if (o_mag_tlast !== 1'b0) begin nerr++; $display("FAIL rst_mag_tlast got %b want 0", o_mag_tlast); end
    nchk++; if (o_peak_valid !== 1'b0) begin nerr++; $display("FAIL rst_peak_valid got %b want 0", o_peak_valid); end
    nchk++; if (o_peak_bin !== 11'd0) begin nerr++; $display("FAIL rst_peak_bin got %0d want 0", o_peak_bin); end
    nchk++; if (o_peak_mag !== 32'd0) begin nerr++; $display("FAIL rst_peak_mag got %0d want 0", o_peak_mag); end
    nchk++; if (o_frame_err !== 1'b0) begin nerr++; $display("FAIL rst_frame_err got %b want 0", o_frame_err); end
    i_fft_tvalid = 1'b0;
    i_fft_tdata  = '0;
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_single_peak();
    int bc, bp, bad;
    do_reset();
    clear_frame();
    fr_re[5] = 16'sd4;
    fr_im[5] = 16'sd3;
    bc = cap_cnt; bp = npulse;
    send_frame(N, 1'b1, 1'b0);
    idle(6);
    bad = 0;
    for (int i = 0; i < N; i++) if (i != 5 && cap_mag[i] !== 32'd0) bad++;
    nchk++; if (cap_mag[5] !== 32'd25) begin nerr++; $display("FAIL t1_mag_bin5 got %0d want 25", cap_mag[5]); end
    nchk++; if (bad != 0) begin nerr++; $display("FAIL t1_other_bins nonzero=%0d want 0", bad); end
    nchk++; if (cap_cnt - bc != N) begin nerr++; $display("FAIL t1_beats got %0d want %0d", cap_cnt - bc, N); end
    nchk++; if (tl_bin !== 11'd2047) begin nerr++; $display("FAIL t1_tlast_bin got %0d want 2047", tl_bin); end
    nchk++; if (last_cyc - tlast_cyc != 2) begin nerr++; $display("FAIL t1_mag_latency got %0d want 2", last_cyc - tlast_cyc); end
    nchk++; if (npulse - bp != 1) begin nerr++; $display("FAIL t1_pulses got %0d want 1", npulse - bp); end
    nchk++; if (pc[bp] - tlast_cyc != 3) begin nerr++; $display("FAIL t1_pulse_latency got %0d want 3", pc[bp] - tlast_cyc); end
    nchk++; if (pb[bp] !== 11'd5) begin nerr++; $display("FAIL t1_peak_bin got %0d want 5", pb[bp]); end
    nchk++; if (pm[bp] !== 32'd25) begin nerr++; $display("FAIL t1_peak_mag got %0d want 25", pm[bp]); end
    nchk++; if (o_peak_bin !== 11'd5 || o_peak_mag !== 32'd25) begin nerr++; $display("FAIL t1_peak_held got %0d/%0d want 5/25", o_peak_bin, o_peak_mag); end
    nchk++; if (o_frame_err !== 1'b0) begin nerr++; $display("FAIL t1_frame_err got %b want 0", o_frame_err); end
  endtask

  task automatic test_dc_bin();
    int bp;
    logic [10:0] eb;
    logic [31:0] em;
`ifdef SPEC_DC_SKIP_EN
    eb = 11'd700; em = 32'd2500;
`else
    eb = 11'd0;   em = 32'd10000;
`endif
    do_reset();
    clear_frame();
    fr_re[0]   = 16'sd100;
    fr_re[700] = 16'sd50;
    bp = npulse;
    send_frame(N, 1'b1, 1'b1);
    idle(6);
    nchk++; if (cap_mag[0] !== 32'd10000) begin nerr++; $display("FAIL t2_mag_bin0 got %0d want 10000", cap_mag[0]); end
    nchk++; if (cap_mag[700] !== 32'd2500) begin nerr++; $display("FAIL t2_mag_bin700 got %0d want 2500", cap_mag[700]); end
    nchk++; if (npulse - bp != 1) begin nerr++; $display("FAIL t2_pulses got %0d want 1", npulse - bp); end
    nchk++; if (pb[bp] !== eb) begin nerr++; $display("FAIL t2_peak_bin got %0d want %0d", pb[bp], eb); end
    nchk++; if (pm[bp] !== em) begin nerr++; $display("FAIL t2_peak_mag got %0d want %0d", pm[bp], em); end
    nchk++; if (o_frame_err !== 1'b0) begin nerr++; $display("FAIL t2_frame_err got %b want 0", o_frame_err); end
  endtask

  task automatic test_tie_max();
    int bp;
    do_reset();
    clear_frame();
    fr_re[10] = -16'sd32768; fr_im[10] = -16'sd32768;
    fr_re[20] = -16'sd32768; fr_im[20] = -16'sd32768;
    bp = npulse;
    send_frame(N, 1'b1, 1'b0);
    idle(6);
    nchk++; if (cap_mag[10] !== 32'h8000_0000) begin nerr++; $display("FAIL t3_mag_bin10 got %h want 80000000", cap_mag[10]); end
    nchk++; if (cap_mag[20] !== 32'h8000_0000) begin nerr++; $display("FAIL t3_mag_bin20 got %h want 80000000", cap_mag[20]); end
    nchk++; if (pb[bp] !== 11'd10) begin nerr++; $display("FAIL t3_peak_bin got %0d want 10", pb[bp]); end
    nchk++; if (pm[bp] !== 32'h8000_0000) begin nerr++; $display("FAIL t3_peak_mag got %h want 80000000", pm[bp]); end
    nchk++; if (o_frame_err !== 1'b0) begin nerr++; $display("FAIL t3_frame_err got %b want 0", o_frame_err); end
  endtask

  task automatic test_early_tlast();
    int bc, bp, bt;
    do_reset();
    clear_frame();
    fr_re[999] = 16'sd7;
    fr_re[500] = 16'sd6;
    bc = cap_cnt; bp = npulse; bt = ntl;
    send_frame(1001, 1'b1, 1'b0);
    idle(6);
    nchk++; if (o_frame_err !== 1'b1) begin nerr++; $display("FAIL t4_frame_err got %b want 1", o_frame_err); end
    nchk++; if (cap_cnt - bc != 1001) begin nerr++; $display("FAIL t4_beats got %0d want 1001", cap_cnt - bc); end
    nchk++; if (ntl - bt != 1 || tl_bin !== 11'd1000) begin nerr++; $display("FAIL t4_tlast_bin got %0d want 1000", tl_bin); end
    nchk++; if (npulse - bp != 1) begin nerr++; $display("FAIL t4_pulses got %0d want 1", npulse - bp); end
    nchk++; if (pb[bp] !== 11'd999) begin nerr++; $display("FAIL t4_peak_bin got %0d want 999", pb[bp]); end
    nchk++; if (pm[bp] !== 32'd49) begin nerr++; $display("FAIL t4_peak_mag got %0d want 49", pm[bp]); end
    drive(16'sd9, 16'sd0, 1'b0);
    idle(4);
    nchk++; if (last_tuser !== 11'd0) begin nerr++; $display("FAIL t4_next_tuser got %0d want 0", last_tuser); end
    nchk++; if (last_mag !== 32'd81) begin nerr++; $display("FAIL t4_next_mag got %0d want 81", last_mag); end
  endtask

  task automatic test_one_bin();
    int bp;
    logic [31:0] em;
`ifdef SPEC_DC_SKIP_EN
    em = 32'd0;
`else
    em = 32'd49;
`endif
    do_reset();
    bp = npulse;
    drive(16'sd0, 16'sd7, 1'b1);
    idle(6);
    nchk++; if (last_mag !== 32'd49) begin nerr++; $display("FAIL t1b_mag got %0d want 49", last_mag); end
    nchk++; if (npulse - bp != 1) begin nerr++; $display("FAIL t1b_pulses got %0d want 1", npulse - bp); end
    nchk++; if (pb[bp] !== 11'd0 || pm[bp] !== em) begin nerr++; $display("FAIL t1b_peak got %0d/%0d want 0/%0d", pb[bp], pm[bp], em); end
    nchk++; if (o_frame_err !== 1'b1) begin nerr++; $display("FAIL t1b_frame_err got %b want 1", o_frame_err); end
  endtask

  task automatic test_missing_tlast();
    int bp, bt;
    do_reset();
    clear_frame();
    fr_re[100]  = 16'sd1; fr_im[100] = 16'sd1;
    fr_re[2047] = 16'sd2;
    bp = npulse; bt = ntl;
    send_frame(N, 1'b0, 1'b0);
    idle(6);
    nchk++; if (ntl - bt != 1 || tl_bin !== 11'd2047) begin nerr++; $display("FAIL t5_forced_tlast got %0d/%0d want 1/2047", ntl - bt, tl_bin); end
    nchk++; if (o_frame_err !== 1'b1) begin nerr++; $display("FAIL t5_frame_err got %b want 1", o_frame_err); end
    nchk++; if (npulse - bp != 1) begin nerr++; $display("FAIL t5_pulses got %0d want 1", npulse - bp); end
    nchk++; if (pb[bp] !== 11'd2047 || pm[bp] !== 32'd4) begin nerr++; $display("FAIL t5_peak got %0d/%0d want 2047/4", pb[bp], pm[bp]); end
    drive(16'sd3, 16'sd0, 1'b0);
    idle(4);
    nchk++; if (last_tuser !== 11'd0 || last_mag !== 32'd9) begin nerr++; $display("FAIL t5_next_beat got %0d/%0d want 0/9", last_tuser, last_mag); end
  endtask

  task automatic test_back_to_back();
    int bp;
    do_reset();
    bp = npulse;
    clear_frame();
    fr_re[3] = 16'sd5;
    send_frame(N, 1'b1, 1'b0);
    clear_frame();
    fr_re[0] = 16'sd1;
    fr_im[2047] = -16'sd2;
    send_frame(N, 1'b1, 1'b0);
    clear_frame();
    send_frame(300, 1'b0, 1'b0);
    nchk++; if (o_frame_err !== 1'b0) begin nerr++; $display("FAIL t6_frame_err got %b want 0", o_frame_err); end
    nchk++; if (npulse - bp != 2) begin nerr++; $display("FAIL t6_pulses got %0d want 2", npulse - bp); end
    nchk++; if (pb[bp] !== 11'd3 || pm[bp] !== 32'd25) begin nerr++; $display("FAIL t6_peak_a got %0d/%0d want 3/25", pb[bp], pm[bp]); end
    nchk++; if (pb[bp+1] !== 11'd2047 || pm[bp+1] !== 32'd4) begin nerr++; $display("FAIL t6_peak_b got %0d/%0d want 2047/4", pb[bp+1], pm[bp+1]); end
    nchk++; if (pc[bp+1] - pc[bp] != N) begin nerr++; $display("FAIL t6_pulse_gap got %0d want %0d", pc[bp+1] - pc[bp], N); end
    rstn = 1'b0;
    i_fft_tvalid = 1'b1;
    i_fft_tdata  = {16'sd0, 16'sd8};
    idle(3);
    i_fft_tvalid = 1'b0;
    i_fft_tdata  = '0;
    nchk++; if ({o_mag_tvalid, o_mag_tlast, o_peak_valid, o_frame_err} !== 4'b0) begin nerr++; $display("FAIL t6_rst_flags got %b want 0000", {o_mag_tvalid, o_mag_tlast, o_peak_valid, o_frame_err}); end
    nchk++; if (o_peak_bin !== 11'd0 || o_peak_mag !== 32'd0) begin nerr++; $display("FAIL t6_rst_peak got %0d/%0d want 0/0", o_peak_bin, o_peak_mag); end
    nchk++; if (o_mag_tdata !== 32'd0 || o_mag_tuser !== 11'd0) begin nerr++; $display("FAIL t6_rst_mag got %0d/%0d want 0/0", o_mag_tdata, o_mag_tuser); end
    rstn = 1'b1;
    idle(10);
    nchk++; if (npulse - bp != 2) begin nerr++; $display("FAIL t6_no_third_pulse got %0d want 2", npulse - bp); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    i_fft_tvalid = 1'b0;
    i_fft_tlast  = 1'b0;
    i_fft_tdata  = '0;
    for (int i = 0; i < N; i++) cap_mag[i] = '0;
    test_reset();
    test_single_peak();
    test_dc_bin();
    test_tie_max();
    test_early_tlast();
    test_one_bin();
    test_missing_tlast();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
